// File: rtl/pspin_hostmem_dma_wr_arb.sv
// Round-robin arbiter sharing one DMA write-descriptor channel among PORTS requesters,
// tagging each descriptor with its port index and steering completions back by that index.
//
// state | meaning
// IDLE  | pick the next requester (round robin) if an outstanding slot is free
// ISSUE | hold the captured descriptor on m_axis until the DMA interface accepts it
module pspin_hostmem_dma_wr_arb #(
   parameter int PORTS           = 4,
   parameter int ADDR_WIDTH      = 64,
   parameter int RAM_SEL_WIDTH   = 4,
   parameter int RAM_ADDR_WIDTH  = 20,
   parameter int DMA_LEN_WIDTH   = 16,
   parameter int S_TAG_WIDTH     = 8,
   parameter int CL_PORTS        = $clog2(PORTS),
   parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [PORTS*ADDR_WIDTH-1:0]         s_axis_write_desc_dma_addr,
   input  logic [PORTS*RAM_SEL_WIDTH-1:0]      s_axis_write_desc_ram_sel,
   input  logic [PORTS*RAM_ADDR_WIDTH-1:0]     s_axis_write_desc_ram_addr,
   input  logic [PORTS*DMA_LEN_WIDTH-1:0]      s_axis_write_desc_len,
   input  logic [PORTS*S_TAG_WIDTH-1:0]        s_axis_write_desc_tag,
   input  logic [PORTS-1:0]                    s_axis_write_desc_valid,
   output logic [PORTS-1:0]                    s_axis_write_desc_ready,
   output logic [ADDR_WIDTH-1:0]               m_axis_write_desc_dma_addr,
   output logic [RAM_SEL_WIDTH-1:0]            m_axis_write_desc_ram_sel,
   output logic [RAM_ADDR_WIDTH-1:0]           m_axis_write_desc_ram_addr,
   output logic [DMA_LEN_WIDTH-1:0]            m_axis_write_desc_len,
   output logic [M_TAG_WIDTH-1:0]              m_axis_write_desc_tag,
   output logic                                m_axis_write_desc_valid,
   input  logic                                m_axis_write_desc_ready,
   input  logic [M_TAG_WIDTH-1:0]              s_axis_write_desc_status_tag,
   input  logic [3:0]                          s_axis_write_desc_status_error,
   input  logic                                s_axis_write_desc_status_valid,
   output logic [PORTS*S_TAG_WIDTH-1:0]        m_axis_write_desc_status_tag,
   output logic [PORTS*4-1:0]                  m_axis_write_desc_status_error,
   output logic [PORTS-1:0]                    m_axis_write_desc_status_valid,
   output logic [CNT_WIDTH-1:0]                outstanding,
   output logic                                err_status
);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e                       state_q, state_d;
   logic [CL_PORTS-1:0]          rr_q, rr_d;
   logic [CNT_WIDTH-1:0]         outstanding_q, outstanding_d;
   logic                         err_q, err_d;
   logic [ADDR_WIDTH-1:0]        m_addr_q, m_addr_d;
   logic [RAM_SEL_WIDTH-1:0]     m_sel_q, m_sel_d;
   logic [RAM_ADDR_WIDTH-1:0]    m_raddr_q, m_raddr_d;
   logic [DMA_LEN_WIDTH-1:0]     m_len_q, m_len_d;
   logic [M_TAG_WIDTH-1:0]       m_tag_q, m_tag_d;
   logic                         m_valid_q, m_valid_d;
   logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
   logic [PORTS*4-1:0]           st_err_q, st_err_d;
   logic [PORTS-1:0]             st_valid_q, st_valid_d;

   logic [CL_PORTS-1:0]          grant;
   logic                         grant_vld;
   logic [CL_PORTS:0]            idx_w;
   logic [CL_PORTS-1:0]          idx;
   logic                         slot_ok;
   logic                         take;
   logic                         issue;
   logic [CL_PORTS-1:0]          st_port;
   logic                         st_port_ok;
   logic                         st_dec;

   // First requesting port at or above the round-robin pointer, wrapping around.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx_w     = '0;
      idx       = '0;
      for (int i = 0; i < PORTS; i++) begin
         idx_w = {1'b0, rr_q} + (CL_PORTS+1)'(i);
         if (idx_w >= (CL_PORTS+1)'(PORTS))
            idx_w = idx_w - (CL_PORTS+1)'(PORTS);
         idx = idx_w[CL_PORTS-1:0];
         if (!grant_vld && s_axis_write_desc_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   assign slot_ok    = outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING);
   assign take       = (state_q == IDLE) && slot_ok && grant_vld;
   assign issue      = (state_q == ISSUE) && m_axis_write_desc_ready;
   assign st_port    = s_axis_write_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
   assign st_port_ok = {1'b0, st_port} < (CL_PORTS+1)'(PORTS);
   assign st_dec     = s_axis_write_desc_status_valid && (outstanding_q != '0);

   // Ready is forced low while reset is asserted so no requester sees a phantom accept.
   assign s_axis_write_desc_ready = (rstn && take) ? (PORTS'(1) << grant) : '0;

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      m_addr_d      = m_addr_q;
      m_sel_d       = m_sel_q;
      m_raddr_d     = m_raddr_q;
      m_len_d       = m_len_q;
      m_tag_d       = m_tag_q;
      m_valid_d     = m_valid_q;
      outstanding_d = outstanding_q;
      err_d         = err_q;
      st_tag_d      = st_tag_q;
      st_err_d      = st_err_q;
      st_valid_d    = '0;

      case (state_q)
         IDLE: begin
            if (take) begin
               m_addr_d  = s_axis_write_desc_dma_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
               m_sel_d   = s_axis_write_desc_ram_sel[grant*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
               m_raddr_d = s_axis_write_desc_ram_addr[grant*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
               m_len_d   = s_axis_write_desc_len[grant*DMA_LEN_WIDTH +: DMA_LEN_WIDTH];
               m_tag_d   = {grant, s_axis_write_desc_tag[grant*S_TAG_WIDTH +: S_TAG_WIDTH]};
               m_valid_d = 1'b1;
               if ({1'b0, grant} == (CL_PORTS+1)'(PORTS - 1))
                  rr_d = '0;
               else
                  rr_d = grant + CL_PORTS'(1);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (m_axis_write_desc_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A completion and an issue in the same cycle cancel out.
      if (issue && !st_dec)
         outstanding_d = outstanding_q + CNT_WIDTH'(1);
      else if (!issue && st_dec)
         outstanding_d = outstanding_q - CNT_WIDTH'(1);

      if (s_axis_write_desc_status_valid) begin
         if (outstanding_q == '0 || !st_port_ok)
            err_d = 1'b1;
         if (st_port_ok) begin
            st_valid_d[st_port]                      = 1'b1;
            st_tag_d[st_port*S_TAG_WIDTH +: S_TAG_WIDTH] =
               s_axis_write_desc_status_tag[S_TAG_WIDTH-1:0];
            st_err_d[st_port*4 +: 4]                 = s_axis_write_desc_status_error;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         rr_q          <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         m_addr_q      <= '0;
         m_sel_q       <= '0;
         m_raddr_q     <= '0;
         m_len_q       <= '0;
         m_tag_q       <= '0;
         m_valid_q     <= 1'b0;
         st_tag_q      <= '0;
         st_err_q      <= '0;
         st_valid_q    <= '0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         m_addr_q      <= m_addr_d;
         m_sel_q       <= m_sel_d;
         m_raddr_q     <= m_raddr_d;
         m_len_q       <= m_len_d;
         m_tag_q       <= m_tag_d;
         m_valid_q     <= m_valid_d;
         st_tag_q      <= st_tag_d;
         st_err_q      <= st_err_d;
         st_valid_q    <= st_valid_d;
      end
   end

   assign m_axis_write_desc_dma_addr     = m_addr_q;
   assign m_axis_write_desc_ram_sel      = m_sel_q;
   assign m_axis_write_desc_ram_addr     = m_raddr_q;
   assign m_axis_write_desc_len          = m_len_q;
   assign m_axis_write_desc_tag          = m_tag_q;
   assign m_axis_write_desc_valid        = m_valid_q;
   assign m_axis_write_desc_status_tag   = st_tag_q;
   assign m_axis_write_desc_status_error = st_err_q;
   assign m_axis_write_desc_status_valid = st_valid_q;
   assign outstanding                    = outstanding_q;
   assign err_status                     = err_q;

endmodule

// File: doc/pspin_hostmem_dma_wr_arb.md
Name: pspin_hostmem_dma_wr_arb

Overview:
- Round-robin scheduler that shares the single host-memory DMA write descriptor interface among PORTS requesters, e.g. several pspin_hostmem_dma_wr instances or per-cluster engines.
- Prefixes each requester tag with its port index and routes the completion status back to the originating port.
- Bounds the number of in-flight descriptors to MAX_OUTSTANDING.
- Sits between the requesters and the verilog-pcie DMA interface write descriptor/status ports.

Parameters:
PORTS, 4, number of requesters (≥2)
ADDR_WIDTH, 64, host DMA address width
RAM_SEL_WIDTH, 4, DMA RAM select width
RAM_ADDR_WIDTH, 20, DMA RAM address width
DMA_LEN_WIDTH, 16, transfer length width
S_TAG_WIDTH, 8, requester tag width
CL_PORTS, $clog2(PORTS), port index width
M_TAG_WIDTH, S_TAG_WIDTH+CL_PORTS, downstream tag width
MAX_OUTSTANDING, 8, maximum descriptors issued without status
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_axis_write_desc_dma_addr  in  PORTS*ADDR_WIDTH  per-port host address
s_axis_write_desc_ram_sel  in  PORTS*RAM_SEL_WIDTH  per-port RAM select
s_axis_write_desc_ram_addr  in  PORTS*RAM_ADDR_WIDTH  per-port RAM address
s_axis_write_desc_len  in  PORTS*DMA_LEN_WIDTH  per-port length
s_axis_write_desc_tag  in  PORTS*S_TAG_WIDTH  per-port tag
s_axis_write_desc_valid  in  PORTS  per-port request
s_axis_write_desc_ready  out  PORTS  per-port accept
m_axis_write_desc_dma_addr  out  ADDR_WIDTH  to DMA interface
m_axis_write_desc_ram_sel  out  RAM_SEL_WIDTH  to DMA interface
m_axis_write_desc_ram_addr  out  RAM_ADDR_WIDTH  to DMA interface
m_axis_write_desc_len  out  DMA_LEN_WIDTH  to DMA interface
m_axis_write_desc_tag  out  M_TAG_WIDTH  {port index, requester tag}
m_axis_write_desc_valid  out  1  descriptor valid
m_axis_write_desc_ready  in  1  DMA interface accept
s_axis_write_desc_status_tag  in  M_TAG_WIDTH  completion tag
s_axis_write_desc_status_error  in  4  completion error code
s_axis_write_desc_status_valid  in  1  completion strobe (no ready)
m_axis_write_desc_status_tag  out  PORTS*S_TAG_WIDTH  per-port returned tag
m_axis_write_desc_status_error  out  PORTS*4  per-port error code
m_axis_write_desc_status_valid  out  PORTS  per-port completion pulse
outstanding  out  CNT_WIDTH  descriptors in flight
err_status  out  1  sticky: unexpected or misrouted status

Behaviour:
- Reset, asynchronous, rstn low:
  - state IDLE, RR pointer 0, outstanding 0, err_status 0.
  - All m_axis_write_desc_* fields 0, m_axis_write_desc_valid 0.
  - All status outputs 0.
  - s_axis_write_desc_ready all 0 while rstn low.
  - Any in-flight descriptor is forgotten.
- State IDLE:
  - slot_ok = (outstanding < MAX_OUTSTANDING).
  - Grant g = first port with valid set, searching from the RR pointer upward with wrap.
  - If slot_ok and any valid: s_axis_write_desc_ready[g]=1 combinationally (one-hot, only in IDLE). All other ready bits are 0.
  - On that edge, capture port g's fields into the m_ registers.
  - m_tag = {g[CL_PORTS-1:0], s_tag[g]}.
  - m_valid goes to 1; pointer = (g+1) mod PORTS; go to ISSUE.
- State ISSUE:
  - Hold the m_ fields and m_valid=1 until m_axis_write_desc_ready.
  - On ready: m_valid=0 next cycle; outstanding +1; back to IDLE.
  - All s ready bits are 0 in ISSUE.
  - Throughput: at most one descriptor per 2 cycles. Latency from s handshake to m_valid is 1 cycle.
- Status routing:
  - p = status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH].
  - Next cycle: m_status_valid[p]=1 for exactly 1 cycle. Tag = low S_TAG_WIDTH bits, error is passed through.
  - Other ports keep valid 0. Their tag/error hold their last values.
- Outstanding counter:
  - Decrement by 1 on each status_valid.
  - Simultaneous issue handshake and status: count unchanged.
  - Status while count==0: no decrement (saturates at 0), err_status set, status still routed if p<PORTS.
  - Status with p≥PORTS (non-power-of-2 PORTS): dropped, err_status set, count still decremented.
  - err_status clears only on reset.
- Full: outstanding==MAX_OUTSTANDING blocks grants; requester valids may stay high indefinitely. A status in the same cycle frees a slot for the next IDLE evaluation.
- Requesters must hold valid and fields stable until ready. The arbiter never drops a valid request. Fairness: each waiting port is granted within PORTS grants.

Test Plan:
- Reset, then port 2 valid: addr 0x1000, len 512, tag 0x05, other ports idle -> ready[2] pulse. Next cycle m_valid=1, m_tag={2,0x05}=0x205, addr 0x1000, len 512. With m_ready tied 1, outstanding becomes 1.
- All 4 ports valid continuously, m_ready=1 -> grant order 0,1,2,3,0. Each port's ready pulses once per 8 cycles.
- MAX_OUTSTANDING=8 with no status returned -> after 8 issues, ready stays 0 and outstanding=8. A status with tag 0x103 -> m_status_valid[1]=1 for 1 cycle with tag 0x03, and the next grant occurs.
- Status with error 4'h3 arriving on the same cycle as an m handshake -> outstanding unchanged, port-routed error=3.
- Status with outstanding=0 -> err_status=1 and outstanding stays 0. Hold m_ready=0 for 5 cycles during ISSUE -> m fields stable, no s ready pulses.
- rstn low mid-ISSUE -> m_valid=0 and outstanding=0 immediately. After release, the RR pointer restarts at 0.
